// File: rtl/vic_wb_buffer_pkg.sv
// vic_wb_buffer_pkg: shared line/entry types, bus encodings and FSM states for the write-back buffer
package vic_wb_buffer_pkg;
    localparam int NUM_SET_BITS = 4;
    localparam int NUM_TAG_BITS = 9;
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_STORE = 2'd2;
    typedef struct packed {
        logic                    valid;
        logic                    dirty;
        logic [NUM_TAG_BITS-1:0] tag;
        logic [63:0]             data;
    } CACHE_LINE_T;
    typedef struct packed {
        logic                    valid;
        logic [NUM_TAG_BITS-1:0] tag;
        logic [NUM_SET_BITS-1:0] set_index;
        logic [63:0]             data;
    } WB_ENTRY_T;
    typedef enum logic {IDLE, DRAIN} wb_state_t;
endpackage

// File: rtl/vic_wb_buffer_cam.sv
// vic_wb_buffer_cam: content-addressable match of a query against every stored tag
module vic_wb_buffer_cam #(
    parameter int LENGTH   = 4,
    parameter int TAG_SIZE = 8
) (
    input  logic [LENGTH-1:0][TAG_SIZE-1:0] tags,
    input  logic [TAG_SIZE-1:0]             query,
    output logic [LENGTH-1:0]               hits
);
    always_comb
        for (int i = 0; i < LENGTH; i++)
            hits[i] = tags[i] == query;
endmodule

// File: rtl/vic_wb_buffer.sv
// vic_wb_buffer: FIFO of dirty victim lines drained to memory with BUS_STORE,
// plus a youngest-match lookup port for the D-cache miss path.
module vic_wb_buffer
    import vic_wb_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    fired_valid,
    input  CACHE_LINE_T             fired_victim,
    input  logic [NUM_SET_BITS-1:0] fired_set_index,
    input  logic [NUM_TAG_BITS-1:0] lookup_tag,
    input  logic [NUM_SET_BITS-1:0] lookup_set_index,
    output logic                    lookup_hit,
    output logic [63:0]             lookup_data,
    input  logic [3:0]              mem2proc_response,
    output logic [1:0]              proc2mem_command,
    output logic [63:0]             proc2mem_addr,
    output logic [63:0]             proc2mem_data,
    output logic                    stall_evict,
    output logic                    empty,
    output logic                    overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = NUM_TAG_BITS + NUM_SET_BITS;

    WB_ENTRY_T                   entries [DEPTH];
    wb_state_t                   state;
    logic [PW-1:0]               head, tail, pick;
    logic [CW-1:0]               count, count_next;
    logic                        fire, full, enq, deq;
    logic [DEPTH-1:0][TW-1:0]    cam_tags;
    logic [DEPTH-1:0]            cam_hits, valid_vec, hits;
    WB_ENTRY_T                   head_e;

    assign fire       = fired_valid & fired_victim.valid & fired_victim.dirty;
    assign deq        = state == DRAIN && mem2proc_response != 4'd0;
    assign full       = count == CW'(DEPTH);
    // a full buffer still accepts a line when the head leaves in the same cycle
    assign enq        = fire && (!full || deq);
    assign count_next = count + CW'(enq) - CW'(deq);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            state    <= IDLE;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                entries[i] <= '0;
        end else begin
            if (deq) begin
                entries[head].valid <= 1'b0;
                head <= head + PW'(1);
            end
            if (enq) begin
                entries[tail] <= '{valid: 1'b1, tag: fired_victim.tag,
                                   set_index: fired_set_index, data: fired_victim.data};
                tail <= tail + PW'(1);
            end
            if (fire && full && !deq)
                overflow <= 1'b1;
            count <= count_next;
            state <= count_next != '0 ? DRAIN : IDLE;
        end
    end

    assign head_e           = entries[head];
    assign proc2mem_command = state == DRAIN ? BUS_STORE : BUS_NONE;
    assign proc2mem_addr    = state == DRAIN ? 64'({head_e.tag, head_e.set_index, 3'b000}) : '0;
    assign proc2mem_data    = state == DRAIN ? head_e.data : '0;
    assign stall_evict      = count >= CW'(DEPTH - 1);
    assign empty            = count == '0;

    always_comb
        for (int i = 0; i < DEPTH; i++) begin
            cam_tags[i]  = {entries[i].tag, entries[i].set_index};
            valid_vec[i] = entries[i].valid;
        end

    vic_wb_buffer_cam #(.LENGTH(DEPTH), .TAG_SIZE(TW)) u_cam (
        .tags (cam_tags),
        .query({lookup_tag, lookup_set_index}),
        .hits (cam_hits)
    );

    assign hits = cam_hits & valid_vec;

    // walk from oldest to youngest relative to tail so the youngest hit wins
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        pick        = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            pick = tail - PW'(i) - PW'(1);
            if (hits[pick]) begin
                lookup_hit  = 1'b1;
                lookup_data = entries[pick].data;
            end
        end
    end
endmodule

// File: tb/tb_vic_wb_buffer.sv
// tb_vic_wb_buffer: directed stimulus with a store scoreboard checked by an independent monitor
module tb_vic_wb_buffer;
    import vic_wb_buffer_pkg::*;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic                    fired_valid = 1'b0;
    CACHE_LINE_T             fired_victim = '0;
    logic [NUM_SET_BITS-1:0] fired_set_index = '0;
    logic [NUM_TAG_BITS-1:0] lookup_tag = '0;
    logic [NUM_SET_BITS-1:0] lookup_set_index = '0;
    logic                    lookup_hit;
    logic [63:0]             lookup_data;
    logic [3:0]              mem2proc_response = '0;
    logic [1:0]              proc2mem_command;
    logic [63:0]             proc2mem_addr, proc2mem_data;
    logic                    stall_evict, empty, overflow;

    int checks = 0;
    int failures = 0;
    logic [127:0] exp_q [$];

    vic_wb_buffer #(.DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .fired_valid(fired_valid), .fired_victim(fired_victim), .fired_set_index(fired_set_index),
        .lookup_tag(lookup_tag), .lookup_set_index(lookup_set_index),
        .lookup_hit(lookup_hit), .lookup_data(lookup_data),
        .mem2proc_response(mem2proc_response), .proc2mem_command(proc2mem_command),
        .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
        .stall_evict(stall_evict), .empty(empty), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic exp_store(input logic [63:0] addr, input logic [63:0] data);
        exp_q.push_back({addr, data});
    endtask

    task automatic fire(input logic [8:0] tag, input logic [3:0] idx, input logic [63:0] d,
                        input logic v = 1'b1, input logic dy = 1'b1);
        fired_valid     = 1'b1;
        fired_victim    = '{valid: v, dirty: dy, tag: tag, data: d};
        fired_set_index = idx;
        tick();
        fired_valid     = 1'b0;
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1 chk("reset_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        chk("reset_empty", 64'(empty), 64'd1);
        #2 reset = 1'b0;
    endtask

    // monitor: every accepted store must match the oldest expected store
    initial begin
        logic [127:0] e;
        forever begin
            @(negedge clock);
            if (!reset && proc2mem_command == BUS_STORE && mem2proc_response != 4'd0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_store: got addr %h data %h expected none", proc2mem_addr, proc2mem_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("store_addr", proc2mem_addr, e[127:64]);
                    chk("store_data", proc2mem_data, e[63:0]);
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        chk("rst_addr", proc2mem_addr, 64'd0);
        chk("rst_data", proc2mem_data, 64'd0);
        chk("rst_stall", 64'(stall_evict), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_hit", 64'(lookup_hit), 64'd0);
        chk("rst_ldata", lookup_data, 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);

        // single dirty line, stored the cycle after it fires
        exp_store(64'h918, 64'hDEAD);
        fire(9'h12, 4'd3, 64'hDEAD);
        chk("t1_cmd", 64'(proc2mem_command), 64'(BUS_STORE));
        chk("t1_addr", proc2mem_addr, 64'h918);
        chk("t1_data", proc2mem_data, 64'hDEAD);
        mem2proc_response = 4'd1;
        tick();
        mem2proc_response = 4'd0;
        chk("t1_empty", 64'(empty), 64'd1);
        chk("t1_idle", 64'(proc2mem_command), 64'(BUS_NONE));

        // clean and invalid lines are dropped
        fire(9'h20, 4'd2, 64'hBEEF, 1'b1, 1'b0);
        chk("t2_clean_empty", 64'(empty), 64'd1);
        chk("t2_clean_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        fire(9'h21, 4'd2, 64'hBEEF, 1'b0, 1'b1);
        tick();
        chk("t2_inv_empty", 64'(empty), 64'd1);
        chk("t2_inv_cmd", 64'(proc2mem_command), 64'(BUS_NONE));

        // fill, stall, overflow; drain order L1..L4
        exp_store(64'h88, 64'h11);
        exp_store(64'h110, 64'h22);
        exp_store(64'h198, 64'h33);
        exp_store(64'h220, 64'h44);
        fire(9'd1, 4'd1, 64'h11);
        fire(9'd2, 4'd2, 64'h22);
        chk("t3_stall_at2", 64'(stall_evict), 64'd0);
        fire(9'd3, 4'd3, 64'h33);
        chk("t3_stall_at3", 64'(stall_evict), 64'd1);
        fire(9'd4, 4'd4, 64'h44);
        chk("t3_ovf_at4", 64'(overflow), 64'd0);
        fire(9'd5, 4'd5, 64'h55);
        chk("t3_ovf", 64'(overflow), 64'd1);
        chk("t3_head_addr", proc2mem_addr, 64'h88);
        mem2proc_response = 4'd1;
        repeat (4) tick();
        mem2proc_response = 4'd0;
        chk("t3_empty", 64'(empty), 64'd1);
        chk("t3_ovf_sticky", 64'(overflow), 64'd1);

        // full buffer with simultaneous accept and fire
        pulse_reset();
        chk("t4_ovf_cleared", 64'(overflow), 64'd0);
        exp_store(64'h88, 64'h11);
        exp_store(64'h110, 64'h22);
        exp_store(64'h198, 64'h33);
        exp_store(64'h220, 64'h44);
        exp_store(64'h2A8, 64'h55);
        fire(9'd1, 4'd1, 64'h11);
        fire(9'd2, 4'd2, 64'h22);
        fire(9'd3, 4'd3, 64'h33);
        fire(9'd4, 4'd4, 64'h44);
        mem2proc_response = 4'd2;
        fire(9'd5, 4'd5, 64'h55);
        chk("t4_stall_full", 64'(stall_evict), 64'd1);
        chk("t4_ovf", 64'(overflow), 64'd0);
        repeat (4) tick();
        mem2proc_response = 4'd0;
        chk("t4_empty", 64'(empty), 64'd1);
        chk("t4_ovf_end", 64'(overflow), 64'd0);

        // lookup forwarding of duplicate addresses
        exp_store(64'h288, 64'h1);
        exp_store(64'h288, 64'h2);
        lookup_tag = 9'd5;
        lookup_set_index = 4'd1;
        fired_valid = 1'b1;
        fired_victim = '{valid: 1'b1, dirty: 1'b1, tag: 9'd5, data: 64'h1};
        fired_set_index = 4'd1;
        #1 chk("t5_same_cycle_hit", 64'(lookup_hit), 64'd0);
        tick();
        fired_valid = 1'b0;
        chk("t5_hit_a", 64'(lookup_hit), 64'd1);
        chk("t5_data_a", lookup_data, 64'h1);
        fire(9'd5, 4'd1, 64'h2);
        chk("t5_hit", 64'(lookup_hit), 64'd1);
        chk("t5_youngest", lookup_data, 64'h2);
        lookup_set_index = 4'd2;
        #1 chk("t5_miss_idx", 64'(lookup_hit), 64'd0);
        lookup_set_index = 4'd1;
        mem2proc_response = 4'd1;
        tick();
        chk("t5_head_accepting_hit", 64'(lookup_hit), 64'd1);
        chk("t5_head_accepting_data", lookup_data, 64'h2);
        tick();
        mem2proc_response = 4'd0;
        chk("t5_drained_hit", 64'(lookup_hit), 64'd0);
        chk("t5_drained_data", lookup_data, 64'd0);

        // asynchronous reset while draining abandons pending stores
        fire(9'd7, 4'd7, 64'h77);
        fire(9'd8, 4'd8, 64'h88);
        chk("t6_pre_cmd", 64'(proc2mem_command), 64'(BUS_STORE));
        pulse_reset();
        chk("t6_ovf", 64'(overflow), 64'd0);
        chk("t6_hit_cleared", 64'(lookup_hit), 64'd0);
        tick();
        exp_store(64'hFFF8, 64'hC0FFEE);
        fire(9'h1FF, 4'hF, 64'hC0FFEE);
        chk("t6_cmd", 64'(proc2mem_command), 64'(BUS_STORE));
        chk("t6_addr", proc2mem_addr, 64'hFFF8);
        mem2proc_response = 4'd1;
        tick();
        mem2proc_response = 4'd0;
        chk("t6_empty", 64'(empty), 64'd1);
        tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
